// File: rtl/m2_pkg.sv
// Shared definitions for the Milestone 2 block scheduler.
// Contents: FSM state type, block-count constants, and sub-unit mask helpers.
// No logic here; imported by the scheduler and its phase tracker.
package m2_pkg;

  // Lives next to the other state typedefs in define_state.h.
  typedef enum logic [2:0] {
    S_M2_IDLE,
    S_M2_LI_FS,
    S_M2_LI_CT,
    S_M2_MEGA_A,
    S_M2_MEGA_B,
    S_M2_LO_CS,
    S_M2_LO_WS,
    S_M2_DONE
  } M2_state_type;

  // 40x30 Y blocks plus 20x30 blocks for each of U and V.
  localparam int unsigned Y_BLOCKS               = 1200;
  localparam int unsigned UV_BLOCKS              = 600;
  localparam int unsigned NUM_BLOCKS_DEFAULT     = Y_BLOCKS + 2 * UV_BLOCKS;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1023;
  localparam int unsigned PHASE_CNT_W            = 10;

  // Bit positions of the four sub-units in every unit mask.
  localparam int UNIT_FS = 0;
  localparam int UNIT_CT = 1;
  localparam int UNIT_CS = 2;
  localparam int UNIT_WS = 3;

  typedef logic [3:0] unit_mask_t;

  // Sub-units that run during a given phase; empty for IDLE and DONE.
  function automatic unit_mask_t phase_units(input M2_state_type s);
    unit_mask_t m;
    m = '0;
    case (s)
      S_M2_LI_FS:  m[UNIT_FS] = 1'b1;
      S_M2_LI_CT:  m[UNIT_CT] = 1'b1;
      S_M2_MEGA_A: begin
        m[UNIT_CS] = 1'b1;
        m[UNIT_FS] = 1'b1;
      end
      S_M2_MEGA_B: begin
        m[UNIT_CT] = 1'b1;
        m[UNIT_WS] = 1'b1;
      end
      S_M2_LO_CS:  m[UNIT_CS] = 1'b1;
      S_M2_LO_WS:  m[UNIT_WS] = 1'b1;
      default:     m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/m2_phase_tracker.sv
// Collects done flags of the sub-units taking part in the current phase and
// counts how long the phase has lasted.
// Latency: a done sampled at edge n shows in phase_complete_o during cycle n+1.
// Flow control: none; done inputs are level flags, the tracker never stalls.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear_i           phase-entry cycle: drop flags, restart cycle count
//   active_i          a phase with participating units is in progress
//   mask_i            participating units (FS, CT, CS, WS bit order)
//   done_i            raw level done flags from the sub-units
//   phase_complete_o  every participating unit has reported done
//   cycle_cnt_o       cycles spent in the phase so far (saturating)
module m2_phase_tracker
  import m2_pkg::*;
#(
  parameter int unsigned CNT_W = PHASE_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             active_i,
  input  unit_mask_t       mask_i,
  input  unit_mask_t       done_i,
  output logic             phase_complete_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  unit_mask_t       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      // Sub-units still show the previous job's done while their start
      // pulse is high, so nothing is latched in the entry cycle.
      flags_d = '0;
      cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (active_i) begin
      flags_d = flags_q | (done_i & mask_i);
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flags are stale from the previous phase during the entry cycle.
  assign phase_complete_o = active_i && !clear_i && ((flags_q & mask_i) == mask_i);
  assign cycle_cnt_o      = cnt_q;

endmodule

// File: rtl/m2_block_scheduler.sv
// Milestone 2 sequencer: runs fetch S' (FS), compute T (CT), compute S (CS)
// and write S (WS) over every 8x8 block in the two-phase mega-state pipeline,
// and multiplexes the single SRAM port between FS reads and WS writes.
// Latency: a phase ends one cycle after its last participating done is
// sampled; the next phase's start pulses follow on the next edge.
// Flow control: start/done handshakes only; a phase waits indefinitely for
// its units, with a sticky error flag once it exceeds TIMEOUT_CYCLES.
// Ports:
//   CLOCK_50_I, Reset            clock, synchronous active-high reset
//   M2_start / M2_done           frame start pulse (idle only) / completion pulse
//   M2_error                     sticky phase timeout flag
//   block_index                  block currently in CS/WS
//   {FS,CT,CS,WS}_start/_done    sub-unit start pulses / level done flags
//   FS_SRAM_address              FS read address
//   WS_SRAM_address/_we_n        WS write address and write enable
//   SRAM_address, SRAM_we_n      shared SRAM port
module m2_block_scheduler
  import m2_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS     = NUM_BLOCKS_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        M2_start,
  output logic        M2_done,
  output logic        M2_error,
  output logic [11:0] block_index,
  output logic        FS_start,
  output logic        CT_start,
  output logic        CS_start,
  output logic        WS_start,
  input  logic        FS_done,
  input  logic        CT_done,
  input  logic        CS_done,
  input  logic        WS_done,
  input  logic [17:0] FS_SRAM_address,
  input  logic [17:0] WS_SRAM_address,
  input  logic        WS_SRAM_we_n,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n
);

  localparam logic [11:0]            LAST_IDX    = 12'(NUM_BLOCKS - 1);
  localparam logic [PHASE_CNT_W-1:0] TIMEOUT_CNT = PHASE_CNT_W'(TIMEOUT_CYCLES);

  M2_state_type           state_q, state_d;
  logic [11:0]            block_index_q, block_index_d;
  unit_mask_t             start_q, start_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  unit_mask_t             phase_mask;
  unit_mask_t             done_vec;
  logic                   phase_active;
  logic                   phase_entry;
  logic                   phase_complete;
  logic [PHASE_CNT_W-1:0] phase_cnt;

  assign phase_mask   = phase_units(state_q);
  assign phase_active = |phase_mask;
  // Start pulses are high exactly in the first cycle of a phase.
  assign phase_entry  = |start_q;

  always_comb begin
    done_vec          = '0;
    done_vec[UNIT_FS] = FS_done;
    done_vec[UNIT_CT] = CT_done;
    done_vec[UNIT_CS] = CS_done;
    done_vec[UNIT_WS] = WS_done;
  end

  m2_phase_tracker #(
    .CNT_W (PHASE_CNT_W)
  ) u_phase_tracker (
    .clk_i            (CLOCK_50_I),
    .rst_i            (Reset),
    .clear_i          (phase_entry),
    .active_i         (phase_active),
    .mask_i           (phase_mask),
    .done_i           (done_vec),
    .phase_complete_o (phase_complete),
    .cycle_cnt_o      (phase_cnt)
  );

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    block_index_d = block_index_q;
    case (state_q)
      S_M2_IDLE: begin
        if (M2_start) state_d = S_M2_LI_FS;
      end
      S_M2_LI_FS: begin
        if (phase_complete) state_d = S_M2_LI_CT;
      end
      S_M2_LI_CT: begin
        if (phase_complete) state_d = (NUM_BLOCKS == 1) ? S_M2_LO_CS : S_M2_MEGA_A;
      end
      S_M2_MEGA_A: begin
        if (phase_complete) state_d = S_M2_MEGA_B;
      end
      S_M2_MEGA_B: begin
        if (phase_complete) begin
          block_index_d = block_index_q + 12'd1;
          state_d       = (block_index_q + 12'd1 == LAST_IDX) ? S_M2_LO_CS : S_M2_MEGA_A;
        end
      end
      S_M2_LO_CS: begin
        if (phase_complete) state_d = S_M2_LO_WS;
      end
      S_M2_LO_WS: begin
        if (phase_complete) state_d = S_M2_DONE;
      end
      S_M2_DONE: begin
        state_d       = S_M2_IDLE;
        block_index_d = '0;
      end
      default: begin
        state_d       = S_M2_IDLE;
        block_index_d = '0;
      end
    endcase
  end

  // Registered pulses and the sticky error flag.
  always_comb begin
    start_d = '0;
    if (state_d != state_q) begin
      start_d = phase_units(state_d);
    end
    done_d  = (state_d == S_M2_DONE) && (state_q != S_M2_DONE);
    error_d = error_q;
    // The count is stale during the entry cycle, so it is not judged then.
    if (phase_active && !phase_entry && (phase_cnt >= TIMEOUT_CNT)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_q       <= S_M2_IDLE;
      block_index_q <= '0;
      start_q       <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      block_index_q <= block_index_d;
      start_q       <= start_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  // SRAM port: FS owns it while fetching, WS while writing back.
  always_comb begin
    SRAM_address = '0;
    SRAM_we_n    = 1'b1;
    case (state_q)
      S_M2_LI_FS, S_M2_MEGA_A: begin
        SRAM_address = FS_SRAM_address;
      end
      S_M2_MEGA_B, S_M2_LO_WS: begin
        SRAM_address = WS_SRAM_address;
        SRAM_we_n    = WS_SRAM_we_n;
      end
      default: begin
        SRAM_address = '0;
        SRAM_we_n    = 1'b1;
      end
    endcase
  end

  assign FS_start    = start_q[UNIT_FS];
  assign CT_start    = start_q[UNIT_CT];
  assign CS_start    = start_q[UNIT_CS];
  assign WS_start    = start_q[UNIT_WS];
  assign M2_done     = done_q;
  assign M2_error    = error_q;
  assign block_index = block_index_q;

endmodule

// File: tb/tb_m2_block_scheduler.sv
// Bench for m2_block_scheduler: two instances (3 blocks and 1 block) driven by
// behavioural sub-unit models with per-unit latency; a per-instance queue holds
// the expected sequence of phase entries, checked as the pulses appear.
module tb_m2_block_scheduler;
  import m2_pkg::*;

  localparam logic [17:0] FS_ADDR = 18'd76800;
  localparam logic [17:0] WS_ADDR = 18'h2A000;

  localparam logic [4:0] EV_FS   = 5'b00001;
  localparam logic [4:0] EV_CT   = 5'b00010;
  localparam logic [4:0] EV_CS   = 5'b00100;
  localparam logic [4:0] EV_WS   = 5'b01000;
  localparam logic [4:0] EV_DONE = 5'b10000;

  typedef struct packed {
    logic [4:0]  evt;
    logic [11:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m2_start [2];
  logic        m2_done  [2];
  logic        m2_error [2];
  logic [11:0] blk_idx  [2];
  logic [1:0]  fs_start, ct_start, cs_start, ws_start;
  logic [3:0]  done_r   [2];
  logic [17:0] sram_addr [2];
  logic        sram_we_n [2];
  logic [17:0] fs_addr  = FS_ADDR;
  logic [17:0] ws_addr  = WS_ADDR;
  logic        ws_we_n  = 1'b0;

  int   lat    [2][4];
  int   cnt    [2][4];
  exp_t sb_q   [2][$];
  int   ev_cnt [2];
  logic [4:0] last_evt [2];
  int   last_cyc [2];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m2_block_scheduler #(.NUM_BLOCKS(3), .TIMEOUT_CYCLES(1023)) dut0 (
    .CLOCK_50_I(clk), .Reset(rst), .M2_start(m2_start[0]), .M2_done(m2_done[0]),
    .M2_error(m2_error[0]), .block_index(blk_idx[0]),
    .FS_start(fs_start[0]), .CT_start(ct_start[0]), .CS_start(cs_start[0]), .WS_start(ws_start[0]),
    .FS_done(done_r[0][UNIT_FS]), .CT_done(done_r[0][UNIT_CT]),
    .CS_done(done_r[0][UNIT_CS]), .WS_done(done_r[0][UNIT_WS]),
    .FS_SRAM_address(fs_addr), .WS_SRAM_address(ws_addr), .WS_SRAM_we_n(ws_we_n),
    .SRAM_address(sram_addr[0]), .SRAM_we_n(sram_we_n[0])
  );

  m2_block_scheduler #(.NUM_BLOCKS(1), .TIMEOUT_CYCLES(1023)) dut1 (
    .CLOCK_50_I(clk), .Reset(rst), .M2_start(m2_start[1]), .M2_done(m2_done[1]),
    .M2_error(m2_error[1]), .block_index(blk_idx[1]),
    .FS_start(fs_start[1]), .CT_start(ct_start[1]), .CS_start(cs_start[1]), .WS_start(ws_start[1]),
    .FS_done(done_r[1][UNIT_FS]), .CT_done(done_r[1][UNIT_CT]),
    .CS_done(done_r[1][UNIT_CS]), .WS_done(done_r[1][UNIT_WS]),
    .FS_SRAM_address(fs_addr), .WS_SRAM_address(ws_addr), .WS_SRAM_we_n(ws_we_n),
    .SRAM_address(sram_addr[1]), .SRAM_we_n(sram_we_n[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] start_vec(input int i);
    return {ws_start[i], cs_start[i], ct_start[i], fs_start[i]};
  endfunction

  // Cycles between this phase's entry and the next one's.
  function automatic int exp_gap(input int i, input logic [4:0] ev);
    int g = 0;
    for (int u = 0; u < 4; u++) if (ev[u] && lat[i][u] > g) g = lat[i][u];
    return g + 2;
  endfunction

  function automatic logic [17:0] exp_addr(input logic [4:0] ev);
    if (ev[UNIT_FS]) return FS_ADDR;
    if (ev[UNIT_WS]) return WS_ADDR;
    return 18'd0;
  endfunction

  // Sub-unit model: done stays stale through the start cycle, drops, then
  // rises lat cycles after the start pulse and holds.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] sv;
      sv = start_vec(i);
      for (int u = 0; u < 4; u++) begin
        if (rst) begin
          cnt[i][u] = 0;
          done_r[i][u] = 1'b0;
        end else if (sv[u]) begin
          cnt[i][u] = lat[i][u];
        end else if (cnt[i][u] != 0) begin
          done_r[i][u] = (cnt[i][u] == 1);
          cnt[i][u]--;
        end
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] seen;
      exp_t e;
      seen = {m2_done[i], start_vec(i)};
      if (!rst && seen != 5'd0) begin
        ev_cnt[i]++;
        if (sb_q[i].size() == 0) begin
          chk("unexpected_event", {27'd0, seen}, 32'd0);
        end else begin
          e = sb_q[i].pop_front();
          chk("phase_units", {27'd0, seen}, {27'd0, e.evt});
          chk("block_index", {20'd0, blk_idx[i]}, {20'd0, e.idx});
          chk("sram_addr", {14'd0, sram_addr[i]}, {14'd0, exp_addr(e.evt)});
          chk("sram_we_n", {31'd0, sram_we_n[i]}, {31'd0, !e.evt[UNIT_WS]});
          if (last_evt[i] != 5'd0) chk("phase_len", cyc - last_cyc[i], exp_gap(i, last_evt[i]));
          last_evt[i] = e.evt[4] ? 5'd0 : e.evt;
          last_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic push_ev(input int i, input logic [4:0] evt, input int idx);
    exp_t e;
    e.evt = evt;
    e.idx = 12'(idx);
    sb_q[i].push_back(e);
  endtask

  task automatic push_frame(input int i, input int n);
    push_ev(i, EV_FS, 0);
    push_ev(i, EV_CT, 0);
    for (int k = 0; k < n - 1; k++) begin
      push_ev(i, EV_CS | EV_FS, k);
      push_ev(i, EV_CT | EV_WS, k);
    end
    push_ev(i, EV_CS, n - 1);
    push_ev(i, EV_WS, n - 1);
    push_ev(i, EV_DONE, n - 1);
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    m2_start[i] = 1'b1;
    @(negedge clk);
    m2_start[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i);
    for (int c = 0; c < 3000 && sb_q[i].size() != 0; c++) @(negedge clk);
    chk("drain", sb_q[i].size(), 0);
  endtask

  task automatic wait_events(input int i, input int target);
    for (int c = 0; c < 3000 && ev_cnt[i] < target; c++) @(negedge clk);
    chk("evt_wait", {31'd0, ev_cnt[i] >= target}, 32'd1);
  endtask

  task automatic run_frame(input int i, input int n);
    push_frame(i, n);
    pulse_start(i);
    wait_drain(i);
  endtask

  task automatic chk_idle(input int i, input string pfx);
    chk({pfx, "_starts"}, {28'd0, start_vec(i)}, 32'd0);
    chk({pfx, "_m2_done"}, {31'd0, m2_done[i]}, 32'd0);
    chk({pfx, "_m2_error"}, {31'd0, m2_error[i]}, 32'd0);
    chk({pfx, "_block_index"}, {20'd0, blk_idx[i]}, 32'd0);
    chk({pfx, "_sram_addr"}, {14'd0, sram_addr[i]}, 32'd0);
    chk({pfx, "_sram_we_n"}, {31'd0, sram_we_n[i]}, 32'd1);
  endtask

  task automatic set_lat(input int i, input int fs, input int ct, input int cs, input int ws);
    lat[i][UNIT_FS] = fs;
    lat[i][UNIT_CT] = ct;
    lat[i][UNIT_CS] = cs;
    lat[i][UNIT_WS] = ws;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      m2_start[i] = 1'b0;
      ev_cnt[i]   = 0;
      last_evt[i] = 5'd0;
      last_cyc[i] = 0;
      set_lat(i, 5, 5, 5, 5);
    end
    repeat (3) @(negedge clk);
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    rst = 1'b0;

    // Fixed 5-cycle units on 3 blocks, 6-cycle units on 1 block; a stray
    // M2_start mid-run must not disturb the sequence.
    set_lat(1, 6, 6, 6, 6);
    fork
      run_frame(0, 3);
      run_frame(1, 1);
      begin
        repeat (20) @(negedge clk);
        pulse_start(0);
      end
    join
    @(negedge clk);
    chk_idle(0, "end0");
    chk_idle(1, "end1");

    // Uneven latencies: MEGA_A waits for the slow FS (40) not the fast CS (4).
    set_lat(0, 40, 7, 4, 3);
    run_frame(0, 3);
    @(negedge clk);
    chk_idle(0, "end0b");

    // CT stalls in the second MEGA_B: timeout flag, then reset mid-phase.
    set_lat(0, 5, 5, 5, 5);
    base = ev_cnt[0];
    push_frame(0, 3);
    pulse_start(0);
    wait_events(0, base + 5);
    lat[0][UNIT_CT] = 3000;
    wait_events(0, base + 6);
    repeat (1000) @(negedge clk);
    chk("error_before_timeout", {31'd0, m2_error[0]}, 32'd0);
    repeat (40) @(negedge clk);
    chk("error_after_timeout", {31'd0, m2_error[0]}, 32'd1);
    repeat (100) @(negedge clk);
    chk("error_sticky", {31'd0, m2_error[0]}, 32'd1);
    chk("stall_block_index", {20'd0, blk_idx[0]}, 32'd1);
    chk("stall_sram_we_n", {31'd0, sram_we_n[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_idle(0, "midrst");
    rst = 1'b0;
    sb_q[0].delete();
    last_evt[0] = 5'd0;

    // Recovery after reset.
    set_lat(0, 5, 5, 5, 5);
    run_frame(0, 3);
    @(negedge clk);
    chk_idle(0, "end0c");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
